// File: rtl/sync_pkg.sv
// Shared types and helpers for the sync_debounce_edge block and related ff_sync consumers.
package sync_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    CHECK_HIGH  = 2'd1,
    STABLE_HIGH = 2'd2,
    CHECK_LOW   = 2'd3
  } sync_db_state_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/edge_pulse_gen.sv
// Registered level with aligned one-cycle rise/fall pulses; takes the level's next value as input.
module edge_pulse_gen #(
  parameter bit init_level = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic level_d,
  output logic level,
  output logic rise,
  output logic fall
);

  // Pulses compare against the next value so they land in the same cycle as the level change.
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= init_level;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      level <= level_d;
      rise  <= level_d & ~level;
      fall  <= ~level_d & level;
    end
  end

endmodule

// File: rtl/sync_debounce_edge.sv
// Stable-count debounce of a synchronised level with rise/fall event pulses.
// Optional saturating glitch counter: define SYNC_DEBOUNCE_GLITCH_CNT_EN.
module sync_debounce_edge
  import sync_pkg::*;
#(
  parameter int unsigned stable_cycles = 4,
  parameter bit          init_level    = 1'b0,
  parameter int unsigned glitch_w      = 8
) (
  input  logic clk_b,
  input  logic rst_b,
  input  logic sig_sync,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [glitch_w-1:0] glitch_cnt
`endif
);

  localparam int unsigned    CW   = cnt_width(stable_cycles);
  localparam logic [CW-1:0]  LAST = CW'(stable_cycles - 1);
  localparam sync_db_state_t HOME = init_level ? STABLE_HIGH : STABLE_LOW;

  sync_db_state_t state, state_nx;
  logic [CW-1:0]  cnt, cnt_nx;
  logic           level_d;

  always_ff @(posedge clk_b) begin
    if (rst_b) begin
      state <= HOME;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      STABLE_LOW: begin
        if (sig_sync) begin
          if (stable_cycles == 1) begin
            state_nx = STABLE_HIGH;
          end else begin
            state_nx = CHECK_HIGH;
            cnt_nx   = CW'(1);
          end
        end
      end
      CHECK_HIGH: begin
        if (!sig_sync) begin
          state_nx = STABLE_LOW;
          cnt_nx   = '0;
        end else if (cnt == LAST) begin
          state_nx = STABLE_HIGH;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      STABLE_HIGH: begin
        if (!sig_sync) begin
          if (stable_cycles == 1) begin
            state_nx = STABLE_LOW;
          end else begin
            state_nx = CHECK_LOW;
            cnt_nx   = CW'(1);
          end
        end
      end
      CHECK_LOW: begin
        if (sig_sync) begin
          state_nx = STABLE_HIGH;
          cnt_nx   = '0;
        end else if (cnt == LAST) begin
          state_nx = STABLE_LOW;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = HOME;
        cnt_nx   = '0;
      end
    endcase
    // The filtered level is high exactly while in the high half of the state space.
    level_d = (state_nx == STABLE_HIGH) || (state_nx == CHECK_LOW);
  end

  edge_pulse_gen #(
    .init_level(init_level)
  ) u_edge (
    .clk     (clk_b),
    .rst     (rst_b),
    .level_d (level_d),
    .level   (level_out),
    .rise    (rise_pulse),
    .fall    (fall_pulse)
  );

`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  logic abort;
  assign abort = ((state == CHECK_HIGH) && !sig_sync) || ((state == CHECK_LOW) && sig_sync);

  always_ff @(posedge clk_b) begin
    if (rst_b) begin
      glitch_cnt <= '0;
    end else if (abort && (glitch_cnt != '1)) begin
      glitch_cnt <= glitch_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sync_debounce_edge.sv
// Directed self-checking bench for sync_debounce_edge (three parameterisations side by side).
module tb_sync_debounce_edge;
  import sync_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sig_a = 1'b0, sig_b = 1'b1, sig_c = 1'b0;
  logic lvl_a, rise_a, fall_a;
  logic lvl_b, rise_b, fall_b;
  logic lvl_c, rise_c, fall_c;
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] gl_a, gl_b, gl_c;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sync_debounce_edge #(.stable_cycles(4), .init_level(1'b0), .glitch_w(8)) dut_a (
    .clk_b(clk), .rst_b(rst), .sig_sync(sig_a),
    .level_out(lvl_a), .rise_pulse(rise_a), .fall_pulse(fall_a)
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    , .glitch_cnt(gl_a)
`endif
  );

  sync_debounce_edge #(.stable_cycles(4), .init_level(1'b1), .glitch_w(8)) dut_b (
    .clk_b(clk), .rst_b(rst), .sig_sync(sig_b),
    .level_out(lvl_b), .rise_pulse(rise_b), .fall_pulse(fall_b)
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    , .glitch_cnt(gl_b)
`endif
  );

  sync_debounce_edge #(.stable_cycles(1), .init_level(1'b0), .glitch_w(8)) dut_c (
    .clk_b(clk), .rst_b(rst), .sig_sync(sig_c),
    .level_out(lvl_c), .rise_pulse(rise_c), .fall_pulse(fall_c)
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    , .glitch_cnt(gl_c)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tests++;
    if (lvl_a !== 1'b0 || rise_a !== 1'b0 || fall_a !== 1'b0) begin
      fails++;
      $display("FAIL reset_a: level/rise/fall=%b%b%b required 000", lvl_a, rise_a, fall_a);
    end
    tests++;
    if (lvl_b !== 1'b1 || rise_b !== 1'b0 || fall_b !== 1'b0) begin
      fails++;
      $display("FAIL reset_b: level/rise/fall=%b%b%b required 100", lvl_b, rise_b, fall_b);
    end
    tests++;
    if (dut_b.state !== STABLE_HIGH || dut_a.state !== STABLE_LOW) begin
      fails++;
      $display("FAIL reset_state: a=%0d b=%0d required a=0 b=2", dut_a.state, dut_b.state);
    end
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    tests++;
    if (gl_a !== 8'd0 || gl_b !== 8'd0) begin
      fails++;
      $display("FAIL reset_glitch: a=%0d b=%0d required 0", gl_a, gl_b);
    end
`endif
  endtask

  task automatic test_rise();
    sig_a = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      tests++;
      if (lvl_a !== (k >= 4) || rise_a !== (k == 4) || fall_a !== 1'b0) begin
        fails++;
        $display("FAIL rise edge %0d: level/rise/fall=%b%b%b required %b%b0",
                 k, lvl_a, rise_a, fall_a, k >= 4, k == 4);
      end
    end
  endtask

  task automatic test_fall();
    sig_a = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      tests++;
      if (lvl_a !== (k < 4) || fall_a !== (k == 4) || rise_a !== 1'b0) begin
        fails++;
        $display("FAIL fall edge %0d: level/rise/fall=%b%b%b required %b0%b",
                 k, lvl_a, rise_a, fall_a, k < 4, k == 4);
      end
    end
  endtask

  task automatic test_glitch();
    int bad;
    bad = 0;
    for (int n = 0; n < 300; n++) begin
      sig_a = 1'b1;
      for (int k = 0; k < 3; k++) begin
        tick();
        if (lvl_a !== 1'b0 || rise_a !== 1'b0 || fall_a !== 1'b0) bad++;
      end
      sig_a = 1'b0;
      tick();
      if (lvl_a !== 1'b0 || rise_a !== 1'b0 || fall_a !== 1'b0) bad++;
      if (n == 0) begin
        tests++;
        if (dut_a.state !== STABLE_LOW || dut_a.cnt !== 3'd0) begin
          fails++;
          $display("FAIL glitch_abort: state=%0d cnt=%0d required 0 0", dut_a.state, dut_a.cnt);
        end
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
        tests++;
        if (gl_a !== 8'd1) begin
          fails++;
          $display("FAIL glitch_one: count=%0d required 1", gl_a);
        end
`endif
      end
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL glitch_level: %0d cycles with level/pulse activity, required 0", bad);
    end
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    tests++;
    if (gl_a !== 8'd255) begin
      fails++;
      $display("FAIL glitch_saturate: count=%0d required 255", gl_a);
    end
`endif
  endtask

  task automatic test_toggle();
    logic v;
    int bad;
    bad = 0;
    v = 1'b0;
    for (int k = 0; k < 12; k++) begin
      v = ~v;
      sig_c = v;
      tick();
      if (lvl_c !== v || rise_c !== v || fall_c !== ~v) begin
        bad++;
        $display("FAIL toggle cycle %0d: level/rise/fall=%b%b%b required %b%b%b",
                 k, lvl_c, rise_c, fall_c, v, v, ~v);
      end
    end
    tests++;
    if (bad != 0) fails++;
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    tests++;
    if (gl_c !== 8'd0) begin
      fails++;
      $display("FAIL toggle_glitch: count=%0d required 0", gl_c);
    end
`endif
  endtask

  task automatic test_reset_mid();
    sig_a = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (lvl_a !== 1'b0 || rise_a !== 1'b0 || dut_a.state !== STABLE_LOW || dut_a.cnt !== 3'd0) begin
      fails++;
      $display("FAIL reset_mid: level=%b rise=%b state=%0d cnt=%0d required 0 0 0 0",
               lvl_a, rise_a, dut_a.state, dut_a.cnt);
    end
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    tests++;
    if (gl_a !== 8'd0) begin
      fails++;
      $display("FAIL reset_mid_glitch: count=%0d required 0", gl_a);
    end
`endif
    for (int k = 1; k <= 5; k++) begin
      tick();
      tests++;
      if (lvl_a !== (k >= 4) || rise_a !== (k == 4)) begin
        fails++;
        $display("FAIL reset_mid_recount edge %0d: level/rise=%b%b required %b%b",
                 k, lvl_a, rise_a, k >= 4, k == 4);
      end
    end
  endtask

  task automatic test_init_high_hold();
    for (int k = 0; k < 4; k++) begin
      tick();
      tests++;
      if (lvl_b !== 1'b1 || rise_b !== 1'b0 || fall_b !== 1'b0) begin
        fails++;
        $display("FAIL init_high_hold %0d: level/rise/fall=%b%b%b required 100",
                 k, lvl_b, rise_b, fall_b);
      end
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_rise();
    test_fall();
    test_glitch();
    test_toggle();
    test_reset_mid();
    test_init_high_hold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
